// File: rtl/bcam_ctrl.sv
// bcam_ctrl: command sequencer in front of a binary CAM.
// Serialises WRITE / INSERT / DELETE / SEARCH commands, keeps a valid bitmap
// and occupancy count, covers the CAM write-to-search hazard and match latency.
// Optional statistics counters are compiled in with `define BCAM_CTRL_STATS_EN.
module bcam_ctrl #(
  parameter int CAMD  = 16,
  parameter int CAMW  = 8,
  parameter int ADDRW = $clog2(CAMD),
  parameter int MLAT  = 2,
  parameter int WLAT  = 1,
  parameter logic [CAMW-1:0] DEL_PATT = {CAMW{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [ADDRW-1:0] cmd_addr,
  input  logic [CAMW-1:0]  cmd_patt,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_hit,
  output logic [ADDRW-1:0] rsp_addr,
  output logic             rsp_err,
  output logic             wEnb,
  output logic [ADDRW-1:0] wAddr,
  output logic [CAMW-1:0]  wPatt,
  output logic [CAMW-1:0]  mPatt,
  input  logic             match,
  input  logic [ADDRW-1:0] mAddr,
`ifdef BCAM_CTRL_STATS_EN
  output logic [31:0]      stat_hits,
  output logic [31:0]      stat_misses,
  output logic [31:0]      stat_full,
`endif
  output logic [ADDRW:0]   occ
);

  localparam logic [1:0] OP_WRITE  = 2'd0;
  localparam logic [1:0] OP_INSERT = 2'd1;
  localparam logic [1:0] OP_DELETE = 2'd2;
  localparam logic [1:0] OP_SEARCH = 2'd3;

  typedef enum logic [2:0] {IDLE, WR, SRCH, WAITM, RESP} state_t;

  state_t            state, nextState;
  logic              accept;
  logic [1:0]        opReg;
  logic [ADDRW-1:0]  addrReg;
  logic [CAMW-1:0]   pattReg;
  logic [CAMD-1:0]   validMap;
  logic [1:0]        hazardCnt;
  logic [2:0]        latCnt;
  logic [ADDRW-1:0]  freeAddr;
  logic              freeFound;
  logic [ADDRW-1:0]  tgtAddr;
  logic              doWrite;
  logic              searchHit;

  // Lowest-index free slot for INSERT allocation
  always_comb begin
    freeAddr  = '0;
    freeFound = 1'b0;
    for (int i = CAMD - 1; i >= 0; i--) begin
      if (!validMap[i]) begin
        freeFound = 1'b1;
        freeAddr  = ADDRW'(i);
      end
    end
  end

  // Write target and whether a CAM write happens for the registered command
  always_comb begin
    tgtAddr   = (opReg == OP_INSERT) ? freeAddr : addrReg;
    doWrite   = (opReg != OP_INSERT) || freeFound;
    searchHit = match && validMap[mAddr];
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  // Next-state logic: one command in flight, response handshake returns to IDLE
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (accept) nextState = (cmd_op == OP_SEARCH) ? SRCH : WR;
      WR:      nextState = RESP;
      SRCH:    if (hazardCnt == 2'd0) nextState = WAITM;
      WAITM:   if (latCnt == 3'd0) nextState = RESP;
      RESP:    if (rsp_valid && rsp_ready) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Command handshake outputs
  always_comb begin
    cmd_ready = (state == IDLE) && !rsp_valid;
    accept    = cmd_valid && cmd_ready;
  end

  // Datapath: command capture, CAM write/match drive, bitmap, occupancy, responses
  always_ff @(posedge clk) begin
    if (rst) begin
      opReg     <= OP_WRITE;
      addrReg   <= '0;
      pattReg   <= '0;
      validMap  <= '0;
      occ       <= '0;
      hazardCnt <= '0;
      latCnt    <= '0;
      rsp_valid <= 1'b0;
      rsp_hit   <= 1'b0;
      rsp_addr  <= '0;
      rsp_err   <= 1'b0;
      wEnb      <= 1'b0;
      wAddr     <= '0;
      wPatt     <= '0;
      mPatt     <= '0;
    end else begin
      wEnb <= 1'b0;
      if (accept) begin
        opReg   <= cmd_op;
        addrReg <= cmd_addr;
        pattReg <= cmd_patt;
      end
      if (state == WR) begin
        hazardCnt <= 2'(WLAT);
      end else if ((state == IDLE || state == SRCH) && hazardCnt != 2'd0) begin
        hazardCnt <= hazardCnt - 2'd1;
      end
      case (state)
        WR: begin
          rsp_err <= !doWrite;
          rsp_hit <= doWrite;
          rsp_addr <= doWrite ? tgtAddr : '0;
          if (doWrite) begin
            wEnb  <= 1'b1;
            wAddr <= tgtAddr;
            if (opReg == OP_DELETE) begin
              wPatt <= DEL_PATT;
              validMap[tgtAddr] <= 1'b0;
              if (validMap[tgtAddr] && occ != '0) occ <= occ - 1'b1;
            end else begin
              wPatt <= pattReg;
              validMap[tgtAddr] <= 1'b1;
              if (!validMap[tgtAddr] && occ != (ADDRW+1)'(CAMD)) occ <= occ + 1'b1;
            end
          end
        end
        SRCH: begin
          if (hazardCnt == 2'd0) begin
            mPatt  <= pattReg;
            latCnt <= 3'(MLAT - 1);
          end
        end
        WAITM: begin
          if (latCnt != 3'd0) begin
            latCnt <= latCnt - 3'd1;
          end else begin
            rsp_hit  <= searchHit;
            rsp_addr <= searchHit ? mAddr : '0;
            rsp_err  <= 1'b0;
          end
        end
        default: ;
      endcase
      if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;
      else if (state == RESP)     rsp_valid <= 1'b1;
    end
  end

`ifdef BCAM_CTRL_STATS_EN
  // Saturating hit/miss/full counters
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_hits   <= '0;
      stat_misses <= '0;
      stat_full   <= '0;
    end else begin
      if (state == WAITM && latCnt == 3'd0) begin
        if (searchHit) begin
          if (stat_hits != 32'hFFFF_FFFF) stat_hits <= stat_hits + 32'd1;
        end else begin
          if (stat_misses != 32'hFFFF_FFFF) stat_misses <= stat_misses + 32'd1;
        end
      end
      if (state == WR && !doWrite && stat_full != 32'hFFFF_FFFF) stat_full <= stat_full + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bcam_ctrl.sv
// Self-checking bench for bcam_ctrl with a behavioural CAM attached to its ports
// and an array-based reference model of slots, patterns and occupancy.
module tb_bcam_ctrl;

  localparam int CAMD = 16;
  localparam int CAMW = 8;
  localparam int ADDRW = 4;
  localparam int MLAT = 2;
  localparam int WLAT = 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'd0;
  logic [ADDRW-1:0] cmd_addr = '0;
  logic [CAMW-1:0]  cmd_patt = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic             rsp_hit;
  logic [ADDRW-1:0] rsp_addr;
  logic             rsp_err;
  logic             wEnb;
  logic [ADDRW-1:0] wAddr;
  logic [CAMW-1:0]  wPatt;
  logic [CAMW-1:0]  mPatt;
  logic             match;
  logic [ADDRW-1:0] mAddr;
  logic [ADDRW:0]   occ;

  bcam_ctrl #(.CAMD(CAMD), .CAMW(CAMW), .MLAT(MLAT), .WLAT(WLAT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_patt(cmd_patt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit),
    .rsp_addr(rsp_addr), .rsp_err(rsp_err),
    .wEnb(wEnb), .wAddr(wAddr), .wPatt(wPatt), .mPatt(mPatt),
    .match(match), .mAddr(mAddr), .occ(occ)
  );

  always #5 clk = ~clk;

  // Behavioural CAM: storage survives controller reset, match delayed by MLAT
  logic             camInit = 1'b1;
  logic [CAMW-1:0]  camMem [CAMD];
  logic             combMatch;
  logic [ADDRW-1:0] combAddr;
  logic             matchQ = 1'b0;
  logic [ADDRW-1:0] mAddrQ = '0;
  int               wEnbCount = 0;
  logic [ADDRW-1:0] lastWAddr = '0;
  logic [CAMW-1:0]  lastWPatt = '0;

  always @(posedge clk) begin
    if (camInit) begin
      for (int i = 0; i < CAMD; i++) camMem[i] <= 8'hFF;
    end else if (wEnb) begin
      camMem[wAddr] <= wPatt;
    end
  end

  always_comb begin
    combMatch = 1'b0;
    combAddr  = '0;
    for (int i = CAMD - 1; i >= 0; i--) begin
      if (camMem[i] == mPatt) begin
        combMatch = 1'b1;
        combAddr  = ADDRW'(i);
      end
    end
  end

  always @(posedge clk) begin
    matchQ <= combMatch;
    mAddrQ <= combAddr;
  end
  assign match = matchQ;
  assign mAddr = mAddrQ;

  // Observes every CAM write strobe the controller issues
  always @(posedge clk) begin
    if (wEnb === 1'b1) begin
      wEnbCount <= wEnbCount + 1;
      lastWAddr <= wAddr;
      lastWPatt <= wPatt;
    end
  end

  // Reference model: slot contents, valid flags
  logic [CAMW-1:0] modelMem [CAMD];
  bit              modelValid [CAMD];
  int checkCount = 0;
  int passCount  = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
  endtask

  function automatic int modelOcc();
    int n = 0;
    for (int i = 0; i < CAMD; i++) if (modelValid[i]) n++;
    return n;
  endfunction

  task automatic applyReset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < CAMD; i++) modelValid[i] = 1'b0;
  endtask

  // Issues one command, checks its response, write strobes, latency and occupancy
  task automatic applyStimulus(input logic [1:0] op, input logic [3:0] addr,
                               input logic [7:0] patt, input int holdCycles);
    logic expHit, expErr;
    logic [3:0] expAddr, expWAddr;
    logic [7:0] expWPatt;
    int expWrites, startW, waitCnt, lat, idx;
    expHit = 1'b0; expErr = 1'b0; expAddr = '0; expWAddr = '0; expWPatt = '0; expWrites = 0;
    case (op)
      2'd0: begin expHit = 1'b1; expAddr = addr; expWrites = 1; expWAddr = addr; expWPatt = patt; end
      2'd1: begin
        idx = -1;
        for (int i = CAMD - 1; i >= 0; i--) if (!modelValid[i]) idx = i;
        if (idx < 0) expErr = 1'b1;
        else begin
          expHit = 1'b1; expAddr = 4'(idx); expWrites = 1; expWAddr = 4'(idx); expWPatt = patt;
        end
      end
      2'd2: begin expHit = 1'b1; expAddr = addr; expWrites = 1; expWAddr = addr; expWPatt = 8'hFF; end
      default: begin
        idx = -1;
        for (int i = CAMD - 1; i >= 0; i--) if (modelMem[i] == patt) idx = i;
        if (idx >= 0 && modelValid[idx]) begin expHit = 1'b1; expAddr = 4'(idx); end
      end
    endcase
    startW = wEnbCount;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_patt = patt;
    waitCnt = 0;
    while (cmd_ready !== 1'b1 && waitCnt < 50) begin @(negedge clk); waitCnt++; end
    checkOutput("cmdAccepted", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 100) begin @(negedge clk); lat++; end
    checkOutput("rspValid", rsp_valid, 1);
    if (op == 2'd3) begin
      checkOutput("searchLatMin", (lat >= 2 + MLAT), 1);
      checkOutput("searchLatMax", (lat <= 2 + MLAT + WLAT), 1);
    end else begin
      checkOutput("writeLatency", lat, 2);
    end
    checkOutput("rspHit", rsp_hit, expHit);
    checkOutput("rspAddr", rsp_addr, expAddr);
    checkOutput("rspErr", rsp_err, expErr);
    for (int h = 0; h < holdCycles; h++) begin
      @(negedge clk);
      checkOutput("holdValid", rsp_valid, 1);
      checkOutput("holdHit", rsp_hit, expHit);
      checkOutput("holdAddr", rsp_addr, expAddr);
      checkOutput("holdErr", rsp_err, expErr);
      checkOutput("holdCmdReady", cmd_ready, 0);
      checkOutput("holdWEnb", wEnb, 0);
      if (op == 2'd3) checkOutput("holdMPatt", mPatt, patt);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checkOutput("rspDropped", rsp_valid, 0);
    checkOutput("cmdReadyAfter", cmd_ready, 1);
    checkOutput("writeCount", wEnbCount - startW, expWrites);
    if (expWrites == 1) begin
      checkOutput("wAddr", lastWAddr, expWAddr);
      checkOutput("wPatt", lastWPatt, expWPatt);
    end
    if (expWrites == 1) begin
      modelMem[expWAddr] = expWPatt;
      modelValid[expWAddr] = (op != 2'd2);
    end
    checkOutput("occ", occ, modelOcc());
  endtask

  initial begin
    int waitCnt;
    for (int i = 0; i < CAMD; i++) begin modelMem[i] = 8'hFF; modelValid[i] = 1'b0; end
    applyReset(3);
    camInit = 1'b0;
    @(negedge clk);
    checkOutput("resetRspValid", rsp_valid, 0);
    checkOutput("resetRspHit", rsp_hit, 0);
    checkOutput("resetRspAddr", rsp_addr, 0);
    checkOutput("resetRspErr", rsp_err, 0);
    checkOutput("resetWEnb", wEnb, 0);
    checkOutput("resetWAddr", wAddr, 0);
    checkOutput("resetWPatt", wPatt, 0);
    checkOutput("resetMPatt", mPatt, 0);
    checkOutput("resetOcc", occ, 0);
    checkOutput("resetCmdReady", cmd_ready, 1);

    applyStimulus(2'd0, 4'd5, 8'hA7, 0);
    applyStimulus(2'd3, 4'd0, 8'hA7, 0);

    applyReset(1);
    for (int i = 0; i < 16; i++) applyStimulus(2'd1, 4'd0, 8'(8'h10 + i), 0);
    applyStimulus(2'd1, 4'd0, 8'h20, 0);
    applyStimulus(2'd2, 4'd3, 8'h00, 0);
    applyStimulus(2'd3, 4'd0, 8'h13, 0);
    applyStimulus(2'd1, 4'd0, 8'h55, 0);
    applyStimulus(2'd3, 4'd0, 8'h10, 5);
    applyStimulus(2'd0, 4'd5, 8'hA7, 0);

    // Reset while the search is waiting on the match pipeline
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'd3; cmd_addr = '0; cmd_patt = 8'hA7;
    waitCnt = 0;
    while (cmd_ready !== 1'b1 && waitCnt < 50) begin @(negedge clk); waitCnt++; end
    @(negedge clk);
    cmd_valid = 1'b0;
    waitCnt = 0;
    while (mPatt !== 8'hA7 && waitCnt < 20) begin @(negedge clk); waitCnt++; end
    checkOutput("reachedWaitm", mPatt, 8'hA7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < CAMD; i++) modelValid[i] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checkOutput("abortNoRsp", rsp_valid, 0);
      @(negedge clk);
    end
    checkOutput("abortOcc", occ, 0);
    applyStimulus(2'd3, 4'd0, 8'hA7, 0);

    for (int n = 0; n < 150; n++) begin
      applyStimulus(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                    8'($urandom_range(0, 254)), $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
